// File: rtl/uarc_link_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_link_buffer_pkg
//  Description : Types and defaults shared by the UARC link buffer and core0.
//                Holds the FIFO entry layout and the link state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uarc_link_buffer_pkg;

    localparam int c_word_mag  = 5;
    localparam int c_depth_mag = 2;
    localparam int c_word_w    = 1 << c_word_mag;

    // One queued word: the stream flag selects r_stream over r_send at delivery.
    typedef struct packed {
        logic                stream;
        logic [c_word_w-1:0] data;
    } uarc_entry_t;

    // KILL waits for the receiver's ack; KDONE is the single cycle that acks the sender.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KILL  = 2'd1,
        ST_KDONE = 2'd2
    } link_state_e;

endpackage : uarc_link_buffer_pkg
`default_nettype wire

// File: rtl/uarc_link_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_link_buffer_if
//  Description : Sender and receiver handshake bundle of one UARC link.
//                slave = link buffer view, master = the two cores' view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uarc_link_buffer_if #(
    parameter int WORD_WIDTH = 32
);
    // Sender side
    logic                  s_enable;
    logic                  s_kill;
    logic                  s_incept;
    logic                  s_send;
    logic                  s_stream;
    logic [WORD_WIDTH-1:0] s_data;
    logic [WORD_WIDTH-1:0] s_self_perm;
    logic [WORD_WIDTH-1:0] s_self_addr;
    logic [WORD_WIDTH-1:0] s_incept_perm;
    logic [WORD_WIDTH-1:0] s_incept_addr;
    logic                  s_kill_ack;
    logic                  s_incept_ack;
    logic                  s_send_ack;
    logic                  s_stream_ack;
    // Receiver side
    logic                  r_enable;
    logic                  r_kill;
    logic                  r_incept;
    logic                  r_send;
    logic                  r_stream;
    logic                  r_kill_ack;
    logic                  r_incept_ack;
    logic                  r_send_ack;
    logic                  r_stream_ack;
    logic [WORD_WIDTH-1:0] r_data;
    logic [WORD_WIDTH-1:0] r_self_perm;
    logic [WORD_WIDTH-1:0] r_self_addr;
    logic [WORD_WIDTH-1:0] r_incept_perm;
    logic [WORD_WIDTH-1:0] r_incept_addr;

    modport slave (
        input  s_enable, s_kill, s_incept, s_send, s_stream, s_data,
               s_self_perm, s_self_addr, s_incept_perm, s_incept_addr,
               r_kill_ack, r_incept_ack, r_send_ack, r_stream_ack,
        output s_kill_ack, s_incept_ack, s_send_ack, s_stream_ack,
               r_enable, r_kill, r_incept, r_send, r_stream, r_data,
               r_self_perm, r_self_addr, r_incept_perm, r_incept_addr
    );

    modport master (
        output s_enable, s_kill, s_incept, s_send, s_stream, s_data,
               s_self_perm, s_self_addr, s_incept_perm, s_incept_addr,
               r_kill_ack, r_incept_ack, r_send_ack, r_stream_ack,
        input  s_kill_ack, s_incept_ack, s_send_ack, s_stream_ack,
               r_enable, r_kill, r_incept, r_send, r_stream, r_data,
               r_self_perm, r_self_addr, r_incept_perm, r_incept_addr
    );

endinterface : uarc_link_buffer_if
`default_nettype wire

// File: rtl/uarc_link_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_link_buffer_fifo
//  Description : Small synchronous FIFO with flush and combinational head.
//                Pointers carry one extra wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module uarc_link_buffer_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH_MAG = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_din,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head
);
    localparam int c_DEPTH = 1 << DEPTH_MAG;

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [DEPTH_MAG:0] r_wptr;
    logic [DEPTH_MAG:0] r_rptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[DEPTH_MAG] != r_rptr[DEPTH_MAG]) &&
                     (r_wptr[DEPTH_MAG-1:0] == r_rptr[DEPTH_MAG-1:0]);
    assign o_head  = r_mem[r_rptr[DEPTH_MAG-1:0]];

    // A pop on empty is dropped; a push on full is allowed only when a pop frees the slot.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and storage update; flush discards every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[DEPTH_MAG-1:0]] <= i_din;
                r_wptr                       <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule : uarc_link_buffer_fifo
`default_nettype wire

// File: rtl/uarc_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_link_buffer
//  Description : Point-to-point UARC stage between a core0 sender port and a
//                core0 receiver port. Queues send/stream words, holds one
//                pending incept and forwards kills (kill > incept > send).
//  Revision    : 1.0 - initial release
// ============================================================================
module uarc_link_buffer
    import uarc_link_buffer_pkg::*;
#(
    parameter int WORD_MAG  = c_word_mag,
    parameter int DEPTH_MAG = c_depth_mag
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uarc_link_buffer_if.slave  bus
);
    localparam int c_W = 1 << WORD_MAG;

    link_state_e    r_state;
    logic           r_inc_pend;
    logic           r_kill_strb;
    logic           r_kill_done;
    logic [c_W-1:0] r_self_perm;
    logic [c_W-1:0] r_self_addr;
    logic [c_W-1:0] r_inc_perm;
    logic [c_W-1:0] r_inc_addr;

    logic           w_idle;
    logic           w_kill_take;
    logic           w_inc_ack;
    logic           w_accept;
    logic           w_deliver;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [c_W:0]   w_head;
    logic [c_W:0]   w_din;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_kill_take = w_idle && bus.s_enable && bus.s_kill;
    assign w_inc_ack   = w_idle && bus.s_enable && bus.s_incept && !bus.s_kill && !r_inc_pend;
    assign w_accept    = w_idle && bus.s_enable && (bus.s_send || bus.s_stream) &&
                         !bus.s_kill && !w_full;

    // The head stays hidden while an incept is pending so the incept reaches the receiver first.
    assign w_deliver = w_idle && !w_empty && !r_inc_pend;
    assign w_pop     = w_deliver && (w_head[c_W] ? bus.r_stream_ack : bus.r_send_ack);
    assign w_din     = {bus.s_stream && !bus.s_send, bus.s_data};

    uarc_link_buffer_fifo #(
        .WIDTH     (c_W + 1),
        .DEPTH_MAG (DEPTH_MAG)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (w_kill_take),
        .i_din   (w_din),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Sender acks are decoded combinationally and forced low while reset is asserted.
    assign bus.s_kill_ack   = r_kill_done;
    assign bus.s_incept_ack = w_inc_ack && !reset;
    assign bus.s_send_ack   = w_accept && bus.s_send && !reset;
    assign bus.s_stream_ack = w_accept && bus.s_stream && !bus.s_send && !reset;

    assign bus.r_enable      = !w_idle || r_inc_pend || !w_empty;
    assign bus.r_kill        = r_kill_strb;
    assign bus.r_incept      = r_inc_pend;
    assign bus.r_send        = w_deliver && !w_head[c_W];
    assign bus.r_stream      = w_deliver && w_head[c_W];
    assign bus.r_data        = w_deliver ? w_head[c_W-1:0] : '0;
    assign bus.r_self_perm   = r_self_perm;
    assign bus.r_self_addr   = r_self_addr;
    assign bus.r_incept_perm = r_inc_perm;
    assign bus.r_incept_addr = r_inc_addr;

    // Link FSM with the kill strobes and the single pending-incept slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_kill_strb <= 1'b0;
            r_kill_done <= 1'b0;
            r_inc_pend  <= 1'b0;
            r_inc_perm  <= '0;
            r_inc_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_kill_take) begin
                        r_state     <= ST_KILL;
                        r_kill_strb <= 1'b1;
                        r_inc_pend  <= 1'b0;
                    end else if (w_inc_ack) begin
                        r_inc_pend <= 1'b1;
                        r_inc_perm <= bus.s_incept_perm;
                        r_inc_addr <= bus.s_incept_addr;
                    end else if (r_inc_pend && bus.r_incept_ack) begin
                        r_inc_pend <= 1'b0;
                    end
                end
                ST_KILL: begin
                    if (bus.r_kill_ack) begin
                        r_state     <= ST_KDONE;
                        r_kill_strb <= 1'b0;
                        r_kill_done <= 1'b1;
                    end
                end
                ST_KDONE: begin
                    r_state     <= ST_IDLE;
                    r_kill_done <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_kill_strb <= 1'b0;
                    r_kill_done <= 1'b0;
                end
            endcase
        end
    end

    // Sender self permission/address follow every accepted kill, incept or word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_self_perm <= '0;
            r_self_addr <= '0;
        end else if (w_kill_take || w_inc_ack || w_accept) begin
            r_self_perm <= bus.s_self_perm;
            r_self_addr <= bus.s_self_addr;
        end
    end

endmodule : uarc_link_buffer
`default_nettype wire

// File: tb/tb_uarc_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uarc_link_buffer
//  Description : Self-checking bench for uarc_link_buffer: directed scenarios
//                and random traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uarc_link_buffer;
    localparam int c_W     = 32;
    localparam int c_DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uarc_link_buffer_if #(.WORD_WIDTH(c_W)) bus ();

    uarc_link_buffer #(.WORD_MAG(5), .DEPTH_MAG(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 kill outstanding, 2 kill acked to sender.
    int             m_phase;
    bit             m_pend;
    logic [c_W:0]   m_q[$];
    logic [c_W-1:0] m_self_perm, m_self_addr, m_inc_perm, m_inc_addr;
    bit             e_inc, e_acc, e_deliver;
    bit [3:0]       last_ack;   // {kill, incept, send, stream} acks seen in the last checked cycle

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pend  = 1'b0;
        m_q.delete();
        m_self_perm = '0;
        m_self_addr = '0;
        m_inc_perm  = '0;
        m_inc_addr  = '0;
    endtask

    task automatic compare_outputs();
        bit             idle, e_send_ack, e_stream_ack;
        logic [c_W:0]   head;
        logic [c_W-1:0] e_data;
        idle         = (m_phase == 0);
        e_inc        = idle && bus.s_enable && bus.s_incept && !bus.s_kill && !m_pend;
        e_acc        = idle && bus.s_enable && (bus.s_send || bus.s_stream) && !bus.s_kill &&
                       (m_q.size() < c_DEPTH);
        e_send_ack   = e_acc && bus.s_send;
        e_stream_ack = e_acc && bus.s_stream && !bus.s_send;
        e_deliver    = idle && !m_pend && (m_q.size() > 0);
        head         = e_deliver ? m_q[0] : '0;
        e_data       = head[c_W-1:0];
        last_ack     = {m_phase == 2, e_inc, e_send_ack, e_stream_ack};
        check("sender_acks",
              {bus.s_kill_ack, bus.s_incept_ack, bus.s_send_ack, bus.s_stream_ack}, last_ack);
        check("recv_strobes",
              {bus.r_enable, bus.r_kill, bus.r_incept, bus.r_send, bus.r_stream},
              {m_phase != 0 || m_pend || m_q.size() > 0, m_phase == 1, m_pend,
               e_deliver && !head[c_W], e_deliver && head[c_W]});
        check("r_data", bus.r_data, e_data);
        check("self_words", {bus.r_self_perm, bus.r_self_addr}, {m_self_perm, m_self_addr});
        check("incept_words", {bus.r_incept_perm, bus.r_incept_addr}, {m_inc_perm, m_inc_addr});
    endtask

    task automatic model_update();
        if (m_phase == 0) begin
            if (bus.s_enable && bus.s_kill) begin
                m_q.delete();
                m_pend      = 1'b0;
                m_phase     = 1;
                m_self_perm = bus.s_self_perm;
                m_self_addr = bus.s_self_addr;
            end else begin
                if (e_deliver && (m_q[0][c_W] ? bus.r_stream_ack : bus.r_send_ack))
                    void'(m_q.pop_front());
                if (e_inc) begin
                    m_pend     = 1'b1;
                    m_inc_perm = bus.s_incept_perm;
                    m_inc_addr = bus.s_incept_addr;
                end else if (m_pend && bus.r_incept_ack) begin
                    m_pend = 1'b0;
                end
                if (e_acc) m_q.push_back({bus.s_stream && !bus.s_send, bus.s_data});
                if (e_inc || e_acc) begin
                    m_self_perm = bus.s_self_perm;
                    m_self_addr = bus.s_self_addr;
                end
            end
        end else if (m_phase == 1) begin
            if (bus.r_kill_ack) m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    // One checked clock cycle; inputs change only at posedge+1.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until the chosen sender ack (3 kill, 2 incept, 1 send, 0 stream) is seen.
    task automatic wait_ack(input int which, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = last_ack[which];
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic set_sender(input bit en, input bit kill, input bit inc, input bit snd, input bit strm);
        bus.s_enable = en;
        bus.s_kill   = kill;
        bus.s_incept = inc;
        bus.s_send   = snd;
        bus.s_stream = strm;
    endtask

    task automatic set_recv(input bit ka, input bit ia, input bit sa, input bit ta);
        bus.r_kill_ack   = ka;
        bus.r_incept_ack = ia;
        bus.r_send_ack   = sa;
        bus.r_stream_ack = ta;
    endtask

    task automatic push_word(input bit strm, input logic [c_W-1:0] d, input string tag);
        bus.s_data      = d;
        bus.s_self_perm = $urandom;
        bus.s_self_addr = $urandom;
        set_sender(1'b1, 1'b0, 1'b0, !strm, strm);
        wait_ack(strm ? 0 : 1, tag);
        set_sender(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic recv_pulse(input bit ka, input bit ia, input bit sa, input bit ta, input int delay);
        steps(delay);
        set_recv(ka, ia, sa, ta);
        step();
        set_recv(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset_async();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {bus.s_kill_ack, bus.s_incept_ack, bus.s_send_ack, bus.s_stream_ack,
               bus.r_enable, bus.r_kill, bus.r_incept, bus.r_send, bus.r_stream,
               bus.r_data, bus.r_self_perm, bus.r_self_addr, bus.r_incept_perm, bus.r_incept_addr},
              '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        set_sender(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_recv(1'b0, 1'b0, 1'b0, 1'b0);
        bus.s_data        = '0;
        bus.s_self_perm   = '0;
        bus.s_self_addr   = '0;
        bus.s_incept_perm = '0;
        bus.s_incept_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Send 0xA5 then stream 0x5A; receiver acks each three cycles after it appears.
        push_word(1'b0, 32'hA5, "send_a5_ack");
        push_word(1'b1, 32'h5A, "stream_5a_ack");
        recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 3);
        recv_pulse(1'b0, 1'b0, 1'b0, 1'b1, 3);
        step();
        check("empty_after_drain", bus.r_enable, 1'b0);

        // Five sends into a stalled receiver: the fifth waits until one word is popped.
        for (int i = 1; i <= 4; i++) push_word(1'b0, 32'h10 + i, "fill_send_ack");
        bus.s_data = 32'h15;
        set_sender(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        steps(2);
        recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 0);
        wait_ack(1, "fifth_send_ack");
        set_sender(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);
        steps(2);

        // Incept then send: the incept is presented first and blocks the word.
        bus.s_incept_perm = 32'h3;
        bus.s_incept_addr = 32'h100;
        set_sender(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ack(2, "incept_ack");
        set_sender(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(1'b0, 32'h7, "send_behind_incept");
        check("incept_perm_latched", bus.r_incept_perm, 32'h3);
        recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 2);
        recv_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1);
        recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Three words plus a pending incept, then a kill flushes everything.
        for (int i = 0; i < 3; i++) push_word(i[0], $urandom, "pre_kill_push");
        set_sender(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ack(2, "pre_kill_incept");
        set_sender(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        steps(3);
        set_recv(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_recv(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("kill_ack_seen", last_ack[3], 1'b1);
        set_sender(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("idle_after_kill", bus.r_enable, 1'b0);

        // Send and stream together: send wins; a disabled link ignores everything.
        bus.s_data = 32'hC3;
        set_sender(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ack(1, "send_wins");
        set_sender(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        steps(3);
        set_sender(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        recv_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);

        do_reset_async();
        step();

        // Random traffic with alternating receiver back-pressure.
        for (int i = 0; i < 1500; i++) begin
            bus.s_enable      = ($urandom_range(0, 7) != 0);
            bus.s_kill        = ($urandom_range(0, 39) == 0);
            bus.s_incept      = ($urandom_range(0, 3) == 0);
            bus.s_send        = $urandom_range(0, 1);
            bus.s_stream      = $urandom_range(0, 1);
            bus.s_data        = $urandom;
            bus.s_self_perm   = $urandom;
            bus.s_self_addr   = $urandom;
            bus.s_incept_perm = $urandom;
            bus.s_incept_addr = $urandom;
            if ((i % 200) < 100)
                set_recv($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            else
                set_recv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            if (i == 777) do_reset_async();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uarc_link_buffer
`default_nettype wire
